change_dispenser: RTL and testbench

- Payout-side counterpart to the coffee vending FSM. Takes the change amount the vending FSM reports when it dispenses, and pays that amount out one physical coin at a time to the coin-return mechanism.
- Uses the same coin encoding as the vending FSM's coin input: 2'b01=1, 2'b10=2, 2'b11=3.
- Tracks per-denomination stock, pays greedily (largest coin first), and flags a shortfall when stock cannot cover the request.

---
 rtl/change_dispenser.sv | 92 +++++++++
 tb/tb_change_dispenser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout with per-denomination stock and shortfall reporting
module change_dispenser #(
  parameter int STOCK_INIT = 4,
  parameter int STOCK_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         change_in,
  input  logic               change_valid,
  input  logic               refill,
  output logic [1:0]         coin_out,
  output logic               coin_out_valid,
  input  logic               coin_out_ready,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [3:0]         short_amt,
  output logic [STOCK_W-1:0] stock1,
  output logic [STOCK_W-1:0] stock2,
  output logic [STOCK_W-1:0] stock3
);
  typedef enum logic [1:0] {IDLE, SELECT, OFFER, FIN} state_t;
  localparam logic [STOCK_W-1:0] INIT = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] ONE = STOCK_W'(1);
  state_t state, state_n;
  logic go;
  logic take;
  logic hs;
  logic [3:0] remaining;
  logic [1:0] d;
  assign busy = state != IDLE;
  assign take = state == IDLE && !go && change_valid;
  assign hs = state == OFFER && coin_out_ready;
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // greedy coin choice and next-state selection
  always_comb begin
    d = (remaining >= 4'd3 && stock3 != '0) ? 2'd3 :
        (remaining >= 4'd2 && stock2 != '0) ? 2'd2 :
        (remaining >= 4'd1 && stock1 != '0) ? 2'd1 : 2'd0;
    state_n = state;
    case (state)
      IDLE:   state_n = go ? SELECT : IDLE;
      SELECT: state_n = (d != 2'd0) ? OFFER : FIN;
      OFFER:  state_n = hs ? SELECT : OFFER;
      FIN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // request capture, coin offer, stock bookkeeping and result flags
  always_ff @(posedge clk) begin
    if (reset) begin
      go <= 1'b0;
      remaining <= 4'd0;
      coin_out <= 2'd0;
      coin_out_valid <= 1'b0;
      done <= 1'b0;
      short <= 1'b0;
      short_amt <= 4'd0;
      stock1 <= INIT;
      stock2 <= INIT;
      stock3 <= INIT;
    end else begin
      go <= take;
      done <= state == SELECT && d == 2'd0;
      if (take) remaining <= change_in;
      if (state == IDLE && refill) begin
        stock1 <= INIT;
        stock2 <= INIT;
        stock3 <= INIT;
      end
      if (state == SELECT && d != 2'd0) begin
        coin_out <= d;
        coin_out_valid <= 1'b1;
      end
      if (state == SELECT && d == 2'd0) begin
        short <= remaining != 4'd0;
        short_amt <= remaining;
      end
      if (hs) begin
        coin_out_valid <= 1'b0;
        remaining <= remaining - {2'b00, coin_out};
        if (coin_out == 2'd1 && stock1 != '0) stock1 <= stock1 - ONE;
        if (coin_out == 2'd2 && stock2 != '0) stock2 <= stock2 - ONE;
        if (coin_out == 2'd3 && stock3 != '0) stock3 <= stock3 - ONE;
      end
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed self-checking bench for change_dispenser
module tb_change_dispenser;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] change_in;
  logic change_valid;
  logic refill;
  logic [1:0] coin_out;
  logic coin_out_valid;
  logic coin_out_ready;
  logic busy;
  logic done;
  logic short;
  logic [3:0] short_amt;
  logic [3:0] stock1, stock2, stock3;
  int compares = 0;
  int fails = 0;

  always #5 clk = ~clk;

  change_dispenser #(.STOCK_INIT(4), .STOCK_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .change_in(change_in),
    .change_valid(change_valid),
    .refill(refill),
    .coin_out(coin_out),
    .coin_out_valid(coin_out_valid),
    .coin_out_ready(coin_out_ready),
    .busy(busy),
    .done(done),
    .short(short),
    .short_amt(short_amt),
    .stock1(stock1),
    .stock2(stock2),
    .stock3(stock3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic stocks(input string tag, input int a, input int b, input int c);
    chk({tag, "_stock1"}, 32'(stock1), a);
    chk({tag, "_stock2"}, 32'(stock2), b);
    chk({tag, "_stock3"}, 32'(stock3), c);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    change_valid = 1'b0;
    refill = 1'b0;
    coin_out_ready = 1'b1;
    change_in = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input logic [3:0] amt, input logic [15:0] exp_c, input int n,
                     input logic exp_s, input logic [3:0] exp_a, input int hold, input int inj);
    int c, got, first, dc, left;
    logic sd, bp;
    c = 0; got = 0; first = -1; dc = -1; sd = 1'b0;
    left = hold;
    bp = hold > 0;
    coin_out_ready = !bp;
    change_in = amt;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    while (!sd && c < 200) begin
      change_valid = 1'b0;
      refill = 1'b0;
      if (c == inj) begin
        change_valid = 1'b1;
        refill = 1'b1;
        change_in = 4'd7;
      end
      if (coin_out_valid && first < 0) first = c;
      if (coin_out_valid && !coin_out_ready) begin
        chk("hold_coin", 32'(coin_out), 32'(exp_c[1:0]));
        chk("hold_stock3", 32'(stock3), 4);
        left--;
        if (left <= 0) coin_out_ready = 1'b1;
      end
      if (coin_out_valid && coin_out_ready) begin
        if (got < n) chk($sformatf("coin%0d", got), 32'(coin_out), 32'(exp_c[2*got+:2]));
        got++;
      end
      if (done) begin
        sd = 1'b1;
        dc = c;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    change_valid = 1'b0;
    refill = 1'b0;
    chk("done_seen", 32'(sd), 1);
    chk("coin_count", got, n);
    chk("short", 32'(short), 32'(exp_s));
    chk("short_amt", 32'(short_amt), 32'(exp_a));
    if (!bp) begin
      chk("done_latency", dc, 2 * n + 2);
      if (n > 0) chk("first_valid", first, 2);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done || busy || coin_out_valid) hits++;
    end
    chk(tag, hits, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    change_valid = 1'b0;
    refill = 1'b0;
    coin_out_ready = 1'b1;
    change_in = 4'd0;
    do_reset;
    chk("rst_coin_out", 32'(coin_out), 0);
    chk("rst_valid", 32'(coin_out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_short", 32'(short), 0);
    chk("rst_short_amt", 32'(short_amt), 0);
    stocks("rst", 4, 4, 4);
    run(4'd1, 16'h0001, 1, 1'b0, 4'd0, 0, -1);
    stocks("t1", 3, 4, 4);
    do_reset;
    run(4'd5, 16'h000B, 2, 1'b0, 4'd0, 0, -1);
    stocks("t2", 4, 3, 3);
    do_reset;
    run(4'd5, 16'h000B, 2, 1'b0, 4'd0, 3, -1);
    stocks("t3", 4, 3, 3);
    coin_out_ready = 1'b1;
    do_reset;
    run(4'd15, 16'h06FF, 6, 1'b0, 4'd0, 0, -1);
    stocks("t4a", 3, 3, 0);
    run(4'd9, 16'h056A, 6, 1'b0, 4'd0, 0, -1);
    stocks("t4b", 0, 0, 0);
    run(4'd4, 16'h0000, 0, 1'b1, 4'd4, 0, -1);
    stocks("t4c", 0, 0, 0);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    stocks("t4_refill", 4, 4, 4);
    chk("short_amt_held", 32'(short_amt), 4);
    run(4'd0, 16'h0000, 0, 1'b0, 4'd0, 0, -1);
    stocks("t4_zero", 4, 4, 4);
    do_reset;
    run(4'd5, 16'h000B, 2, 1'b0, 4'd0, 0, 3);
    stocks("t5", 4, 3, 3);
    quiet("t5_no_second", 8);
    do_reset;
    change_in = 4'd5;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_offer_valid", 32'(coin_out_valid), 1);
    chk("t6_offer_coin", 32'(coin_out), 2);
    chk("t6_offer_stock3", 32'(stock3), 3);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_valid", 32'(coin_out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    stocks("t6", 4, 4, 4);
    reset = 1'b0;
    quiet("t6_no_done", 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
